// File: rtl/fetch_pkg.sv
// Shared defaults and the buffered fetch entry type for the instruction fetch stage.
package fetch_pkg;
  localparam int DEF_ADDR_W   = 6;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_RESET_PC = 0;
  localparam logic [15:0] HALT_OPCODE = 16'hFFFF;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] instr;
    logic [DEF_ADDR_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO holding fetched {instr, pc} entries; slot 0 is always the head.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  entry_t     din,
  input  logic       pop,
  input  logic       flush,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t     slot_q [2];
  entry_t     slot_d [2];
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  always_comb begin
    slot_d  = slot_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          slot_d[count_q[0]] = din;
          count_d            = count_q + 2'd1;
        end
        2'b01: begin
          slot_d[0] = slot_q[1];
          count_d   = count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: the new entry lands behind whatever survives the pop.
          if (count_q == 2'd1) begin
            slot_d[0] = din;
          end else begin
            slot_d[0] = slot_q[1];
            slot_d[1] = din;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      count_q   <= 2'd0;
    end else begin
      slot_q  <= slot_d;
      count_q <= count_d;
    end
  end

  assign head  = slot_q[0];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues reads to a 1-cycle synchronous memory and buffers words for decode.
// Optional halt-on-opcode behaviour is enabled by defining FETCH_HALT_EN.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_instr,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              halted
);

  // Decode handshake: a word transfers on a cycle where ir_valid && ir_ready; while
  // ir_valid is high and ir_ready low, ir_instr/ir_pc hold their value.
  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic              pending_q, pending_d;
  logic              halted_s;
  logic              pop;
  logic              push;
  logic              issue;
  logic [1:0]        buf_count;
  logic [2:0]        occupancy;
  entry_t            head;
  entry_t            push_entry;

  assign pop       = ir_valid && ir_ready;
  // Credit: words already buffered plus the one in flight, less the one leaving now.
  assign occupancy = {1'b0, buf_count} + {2'b00, pending_q} - {2'b00, pop};
  assign issue     = !redirect_valid && !halted_s && (occupancy < 3'd2);
  assign push      = pending_q && !redirect_valid && !halted_s;

  assign push_entry.instr = imem_data;
  assign push_entry.pc    = tag_q;

  always_comb begin
    pc_d      = pc_q;
    tag_d     = tag_q;
    pending_d = issue;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d  = pc_q + ADDR_W'(1);
      tag_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= ADDR_W'(RESET_PC);
      tag_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      tag_q     <= tag_d;
      pending_q <= pending_d;
    end
  end

`ifdef FETCH_HALT_EN
  localparam logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_OPCODE);
  logic halted_q, halted_d;

  always_comb begin
    halted_d = halted_q;
    if (redirect_valid) begin
      halted_d = 1'b0;
    end else if (push && (imem_data == HALT_WORD)) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halted_s = halted_q;
`else
  assign halted_s = 1'b0;
`endif

  fetch_buf #(
    .entry_t (entry_t)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .flush (redirect_valid),
    .head  (head),
    .count (buf_count)
  );

  assign imem_en   = issue;
  assign imem_addr = pc_q;
  assign ir_valid  = (buf_count != 2'd0);
  assign ir_instr  = head.instr;
  assign ir_pc     = head.pc;
  assign halted    = halted_s;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory model, stimulus tasks, and a scoreboard monitor
// that checks every decode transfer against the expected queue.
module tb_instr_fetch;
  localparam int AW = 6;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data = '0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          ir_valid;
  logic          ir_ready = 1'b0;
  logic [DW-1:0] ir_instr;
  logic [AW-1:0] ir_pc;
  logic          halted;

  logic [DW-1:0]    mem [64];
  logic [DW+AW-1:0] exp_q [$];
  int               n_cmp = 0;
  int               n_bad = 0;
  int               xfer_cnt = 0;

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .ir_instr       (ir_instr),
    .ir_pc          (ir_pc),
    .halted         (halted)
  );

  // Clock
  always #5 clk = ~clk;

  // Synchronous-read instruction memory
  always @(posedge clk) begin
    if (imem_en) imem_data <= mem[imem_addr];
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [DW+AW-1:0] exp_e;
    if (rst_n && ir_valid && ir_ready) begin
      xfer_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_xfer: got pc=%0d instr=%h, required no transfer", ir_pc, ir_instr);
      end else begin
        exp_e = exp_q.pop_front();
        if ({ir_instr, ir_pc} !== exp_e)
          begin
            n_bad++;
            $display("FAIL xfer_%0d: got pc=%0d instr=%h, required pc=%0d instr=%h",
                     xfer_cnt, ir_pc, ir_instr, exp_e[AW-1:0], exp_e[DW+AW-1:AW]);
          end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] p;
      p = AW'((first + i) % 64);
      exp_q.push_back({mem[p], p});
    end
  endtask

  // Hold ir_ready high until the transfer count reaches target, then drop it.
  task automatic run_until(input int target);
    int guard;
    guard = 0;
    ir_ready = 1'b1;
    while (xfer_cnt < target && guard < 500) begin
      cyc();
      guard++;
    end
    ir_ready = 1'b0;
    if (xfer_cnt < target) check("xfer_timeout", 32'(xfer_cnt), 32'(target));
  endtask

  initial begin
    int issues;
    int base;
    for (int k = 0; k < 64; k++) mem[k] = 16'h1000 + 16'(k);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_ir_instr", 32'(ir_instr), 32'd0);
    check("rst_ir_pc", 32'(ir_pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    // Release: first delivery two cycles later
    cyc();
    rst_n = 1'b1;
    ir_ready = 1'b1;
    push_exp(0, 3);
    check("rel_issue_addr", 32'(imem_addr), 32'd0);
    @(negedge clk);
    check("lat_c0_valid", 32'(ir_valid), 32'd0);
    @(negedge clk);
    check("lat_c1_valid", 32'(ir_valid), 32'd0);
    @(negedge clk);
    check("lat_c2_valid", 32'(ir_valid), 32'd1);
    check("lat_c2_pc", 32'(ir_pc), 32'd0);
    run_until(3);

    // Backpressure for 5 cycles: head (pc 3) must hold, issue must stop
    issues = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (imem_en) issues++;
      check("stall_hold", {8'(ir_valid), 8'(ir_pc), ir_instr}, {8'd1, 8'd3, 16'h1003});
      cyc();
    end
    check("stall_issues_le1", 32'(issues <= 1), 32'd1);
    @(negedge clk);
    check("stall_en_low", 32'(imem_en), 32'd0);

    // Stream through PC wraparound 63 -> 0
    push_exp(3, 64);
    run_until(67);

    // Fill buffer, then redirect to 20
    cyc();
    cyc();
    @(negedge clk);
    check("pre_redir_full_en", 32'(imem_en), 32'd0);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 6'd20;
    cyc();
    redirect_valid = 1'b0;
    push_exp(20, 10);
    @(negedge clk);
    check("redir_t1_valid", 32'(ir_valid), 32'd0);
    check("redir_t1_issue", {16'(imem_en), 16'(imem_addr)}, {16'd1, 16'd20});
    cyc();
    cyc();
    @(negedge clk);
    check("redir_t3_valid_pc", {16'(ir_valid), 16'(ir_pc)}, {16'd1, 16'd20});
    run_until(77);

    // Mid-stream reset with a full buffer
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(ir_valid), 32'd0);
    check("midrst_halted", 32'(halted), 32'd0);
    cyc();
    cyc();
`ifdef FETCH_HALT_EN
    mem[5] = 16'hFFFF;
`endif
    rst_n = 1'b1;
    base = xfer_cnt;
`ifdef FETCH_HALT_EN
    push_exp(0, 6);
    run_until(base + 6);
    ir_ready = 1'b1;
    repeat (6) cyc();
    @(negedge clk);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_en_low", 32'(imem_en), 32'd0);
    check("halt_no_valid", 32'(ir_valid), 32'd0);
    ir_ready = 1'b0;
    cyc();
`else
    push_exp(0, 8);
    run_until(base + 8);
    check("nohalt_halted", 32'(halted), 32'd0);
`endif

    // Redirect to 8 (clears halt when enabled)
    redirect_valid = 1'b1;
    redirect_pc = 6'd8;
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir8_halted", 32'(halted), 32'd0);
    check("redir8_issue", {16'(imem_en), 16'(imem_addr)}, {16'd1, 16'd8});
    base = xfer_cnt;
    push_exp(8, 3);
    run_until(base + 3);

    repeat (4) cyc();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
